// File: rtl/alu_md_pkg.sv
// Shared opcode constants, FSM state type and opcode classifiers for the
// alu_md integer ALU with iterative multiply/divide.
package alu_md_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLTU  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOR   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
  localparam logic [OP_W-1:0] OP_MULT  = 4'b1000;
  localparam logic [OP_W-1:0] OP_MULTU = 4'b1001;
  localparam logic [OP_W-1:0] OP_DIV   = 4'b1010;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'b1011;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'b1100;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // 10xx: mult/multu/div/divu go through the iterative unit
  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  // Even opcodes among the iterative ops are the signed variants
  function automatic logic is_signed_iter(input logic [OP_W-1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/alu_md_if.sv
// Issue/result bundle between the execute stage and alu_md.
interface alu_md_if
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  control;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             of;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, control, in_valid,
    input  in_ready, out_valid, result, of, hi, lo
  );

  modport slave (
    input  a, b, control, in_valid,
    output in_ready, out_valid, result, of, hi, lo
  );
endinterface

// File: rtl/alu_md_iter.sv
// Radix-2 iterative datapath on unsigned magnitudes: shift-add multiply and
// restoring divide, one bit per cycle, WIDTH cycles per operation.
module alu_md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_ma,
  input  logic [WIDTH-1:0] i_mb,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_hi_p0;
  logic [WIDTH-1:0] r_lo_p0;
  logic [WIDTH-1:0] r_m_p0;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // o_hi/o_lo are the values after this cycle's step; the top captures them
  // on the last step so the result lands without an extra cycle.
  always_comb begin
    w_sum   = {1'b0, r_hi_p0} + (r_lo_p0[0] ? {1'b0, r_m_p0} : '0);
    w_shift = {r_hi_p0, r_lo_p0[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_m_p0});
    // When w_ge holds the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    w_diff  = w_shift[WIDTH-1:0] - r_m_p0;
    if (r_is_div) begin
      o_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
      o_lo = {r_lo_p0[WIDTH-2:0], w_ge};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], r_lo_p0[WIDTH-1:1]};
    end
  end

  assign o_done = i_run && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // ---- iteration registers (hi accumulates, lo shifts) ----
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_hi_p0  <= '0;
      r_lo_p0  <= i_ma;
      r_m_p0   <= i_mb;
      r_is_div <= i_is_div;
    end else if (i_run) begin
      r_hi_p0  <= o_hi;
      r_lo_p0  <= o_lo;
    end
  end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: registered single-cycle integer ops plus an iterative
// multiply/divide unit with architectural HI/LO and a valid/ready issue port.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_md_if.slave  io_bus
);
  state_t r_state;
  state_t w_state_nxt;

  logic             w_xfer;
  logic             w_iter_start;
  logic             w_iter_run;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH-1:0] w_iter_lo;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [2*WIDTH-1:0] w_fix;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result_p1;
  logic             r_of_p1;
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_a_p0;
  logic             r_neg_q_p0;
  logic             r_neg_r_p0;
  logic             r_bzero_p0;

  // Returns {of, result} for the single-cycle opcodes; reserved codes give 0.
  function automatic logic [WIDTH:0] alu_single(
    input logic [OP_W-1:0]  op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0]        b2;
    logic [WIDTH-1:0]        sum;
    logic                    ovf;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    b2  = op[2] ? ~b : b;
    sum = a + b2 + {{(WIDTH-1){1'b0}}, op[2]};
    ovf = (a[WIDTH-1] == b2[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sa  = a;
    sb  = b;
    case (op)
      OP_AND:         return {1'b0, a & b};
      OP_OR:          return {1'b0, a | b};
      OP_ADD, OP_SUB: return {ovf, sum};
      OP_SLT:         return {1'b0, {(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU:        return {1'b0, {(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:         return {1'b0, a ^ b};
      OP_NOR:         return {1'b0, ~(a | b)};
      default:        return '0;
    endcase
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_mul(
    input logic [2*WIDTH-1:0] p,
    input logic               neg
  );
    return neg ? -p : p;
  endfunction

  // Returns {hi, lo}; divide-by-zero keeps the dividend in HI regardless of sign.
  function automatic logic [2*WIDTH-1:0] fix_div(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic             neg_q,
    input logic             neg_r,
    input logic             bzero,
    input logic [WIDTH-1:0] a
  );
    if (bzero) return {a, {WIDTH{1'b1}}};
    return {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
  endfunction

  assign w_xfer       = io_bus.in_valid && (r_state == IDLE);
  assign w_iter_start = w_xfer && is_iter_op(io_bus.control);
  assign w_iter_run   = (r_state == MUL) || (r_state == DIV);
  assign w_sa = is_signed_iter(io_bus.control) && io_bus.a[WIDTH-1];
  assign w_sb = is_signed_iter(io_bus.control) && io_bus.b[WIDTH-1];
  assign w_ma = w_sa ? -io_bus.a : io_bus.a;
  assign w_mb = w_sb ? -io_bus.b : io_bus.b;

  assign w_fix = (r_state == DIV)
               ? fix_div(w_iter_hi, w_iter_lo, r_neg_q_p0, r_neg_r_p0, r_bzero_p0, r_a_p0)
               : fix_mul({w_iter_hi, w_iter_lo}, r_neg_q_p0);

  alu_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (reset),
    .i_start  (w_iter_start),
    .i_is_div (io_bus.control[1]),
    .i_run    (w_iter_run),
    .i_ma     (w_ma),
    .i_mb     (w_mb),
    .o_done   (w_iter_done),
    .o_hi     (w_iter_hi),
    .o_lo     (w_iter_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_iter_start) w_state_nxt = io_bus.control[1] ? DIV : MUL;
      MUL, DIV: if (w_iter_done)  w_state_nxt = FIN;
      FIN:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // ---- p0: sign bookkeeping captured at issue of an iterative op ----
  always_ff @(posedge clk) begin
    if (w_iter_start) begin
      r_a_p0     <= io_bus.a;
      r_neg_q_p0 <= w_sa ^ w_sb;
      r_neg_r_p0 <= w_sa;
      r_bzero_p0 <= (io_bus.b == '0);
    end
  end

  // ---- p1: registered result, flags and HI/LO ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi        <= '0;
      r_lo        <= '0;
      r_result_p1 <= '0;
      r_of_p1     <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (w_xfer && !is_iter_op(io_bus.control)) begin
        r_vld_p1 <= 1'b1;
        r_of_p1  <= 1'b0;
        case (io_bus.control)
          OP_MFHI: r_result_p1 <= r_hi;
          OP_MFLO: r_result_p1 <= r_lo;
          default: {r_of_p1, r_result_p1} <= alu_single(io_bus.control, io_bus.a, io_bus.b);
        endcase
      end
      if (w_iter_done) begin
        {r_hi, r_lo} <= w_fix;
        r_result_p1  <= w_fix[WIDTH-1:0];
        r_of_p1      <= 1'b0;
        r_vld_p1     <= 1'b1;
      end
    end
  end

  assign io_bus.in_ready  = (r_state == IDLE);
  assign io_bus.out_valid = r_vld_p1;
  assign io_bus.result    = r_result_p1;
  assign io_bus.of        = r_of_p1;
  assign io_bus.hi        = r_hi;
  assign io_bus.lo        = r_lo;

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md (WIDTH=32): an arithmetic reference model feeds a
// timed scoreboard that is compared against the DUT outputs every cycle.
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_md_if #(.WIDTH(W)) bus ();
  alu_md #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .io_bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic       multi;
    logic       of;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;
  int m_busy_lo = 0;
  int m_free = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] v_hi = '0;
  logic [W-1:0] v_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ready_at(input int k);
    return !(k >= m_busy_lo && k < m_free);
  endfunction

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] h, input logic [W-1:0] l);
    exp_t e;
    longint sx, sy, r, rm;
    logic [63:0] pu;
    e = '0;
    e.hi = h;
    e.lo = l;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (c)
      OP_AND:  e.res = x & y;
      OP_OR:   e.res = x | y;
      OP_XOR:  e.res = x ^ y;
      OP_NOR:  e.res = ~(x | y);
      OP_ADD:  begin r = sx + sy; e.res = x + y; e.of = (r != longint'($signed(e.res))); end
      OP_SUB:  begin r = sx - sy; e.res = x - y; e.of = (r != longint'($signed(e.res))); end
      OP_SLT:  e.res = (sx < sy) ? 1 : 0;
      OP_SLTU: e.res = (x < y) ? 1 : 0;
      OP_MFHI: e.res = h;
      OP_MFLO: e.res = l;
      OP_MULT: begin r = sx * sy; {e.hi, e.lo} = r; end
      OP_MULTU: begin pu = {32'b0, x} * {32'b0, y}; {e.hi, e.lo} = pu; end
      OP_DIV: begin
        if (y == 0) begin e.lo = '1; e.hi = x; end
        else begin r = sx / sy; rm = sx % sy; e.lo = r[31:0]; e.hi = rm[31:0]; end
      end
      OP_DIVU: begin
        if (y == 0) begin e.lo = '1; e.hi = x; end
        else begin e.lo = x / y; e.hi = x % y; end
      end
      default: e.res = '0;
    endcase
    e.multi = (c[3:2] == 2'b10);
    if (e.multi) e.res = e.lo;
    return e;
  endfunction

  // Per-cycle comparison against the scoreboard
  always @(negedge clk) begin : cmp
    logic ev;
    exp_t e;
    if (reset) begin
      q.delete();
      v_hi = '0;
      v_lo = '0;
    end else begin
      ev = (q.size() > 0) && (q[0].cyc == cyc);
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, ev});
      if (ev) begin
        e = q.pop_front();
        chk("result", bus.result, e.res);
        chk("of", {31'b0, bus.of}, {31'b0, e.of});
        if (e.multi) begin
          v_hi = e.hi;
          v_lo = e.lo;
        end
      end
      chk("hi", bus.hi, v_hi);
      chk("lo", bus.lo, v_lo);
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, ready_at(cyc)});
    end
  end

  task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    int waited;
    exp_t e;
    waited = 0;
    bus.control  = c;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    while (!ready_at(cyc)) begin
      if (waited > 100) begin
        n_vec++;
        n_fail++;
        $display("FAIL issue_timeout: op %b not accepted after %0d cycles", c, waited);
        bus.in_valid = 1'b0;
        return;
      end
      waited++;
      @(posedge clk); #1;
    end
    e = model(c, x, y, m_hi, m_lo);
    if (e.multi) begin
      e.cyc     = cyc + LAT;
      m_busy_lo = cyc + 1;
      m_free    = cyc + LAT + 1;
      m_hi      = e.hi;
      m_lo      = e.lo;
    end else begin
      e.cyc = cyc + 1;
    end
    q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom();
    bus.b = $urandom();
    bus.control = 4'(c + 4'd5);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_busy_lo = 0;
    m_free = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t p;
    bus.a = '0;
    bus.b = '0;
    bus.control = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_result", bus.result, 32'h0);
    chk("rst_of", {31'b0, bus.of}, 32'h0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

    // Hand-computed values that pin the reference model
    p = model(OP_ADD, 32'h7FFFFFFF, 32'h1, '0, '0);
    chk("pin_add", p.res, 32'h80000000);
    chk("pin_add_of", {31'b0, p.of}, 32'h1);
    p = model(OP_SUB, 32'd5, 32'd7, '0, '0);
    chk("pin_sub", p.res, 32'hFFFFFFFE);
    chk("pin_sub_of", {31'b0, p.of}, 32'h0);
    p = model(OP_MULT, 32'hFFFFFFFD, 32'd7, '0, '0);
    chk("pin_mult_hi", p.hi, 32'hFFFFFFFF);
    chk("pin_mult_lo", p.lo, 32'hFFFFFFEB);
    p = model(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0);
    chk("pin_multu_hi", p.hi, 32'hFFFFFFFE);
    chk("pin_multu_lo", p.lo, 32'h00000001);
    p = model(OP_DIV, 32'hFFFFFFF9, 32'd2, '0, '0);
    chk("pin_div_lo", p.lo, 32'hFFFFFFFD);
    chk("pin_div_hi", p.hi, 32'hFFFFFFFF);
    p = model(OP_DIV, 32'h80000000, 32'hFFFFFFFF, '0, '0);
    chk("pin_divmin_lo", p.lo, 32'h80000000);
    chk("pin_divmin_hi", p.hi, 32'h0);

    // Single-cycle ops, issued back-to-back
    issue(OP_ADD,  32'h7FFFFFFF, 32'h00000001);
    issue(OP_SUB,  32'd5,        32'd7);
    issue(OP_SLT,  32'hFFFFFFFF, 32'd1);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'd1);
    issue(OP_NOR,  32'h0,        32'h0);
    issue(OP_AND,  32'hF0F0A5A5, 32'h0FF0FFFF);
    issue(OP_OR,   32'hF0000001, 32'h0000F000);
    issue(OP_XOR,  32'hAAAA5555, 32'hFFFF0000);
    issue(OP_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(OP_SUB,  32'h80000000, 32'h00000001);
    issue(OP_ADD,  32'h80000000, 32'h80000000);
    issue(OP_SLT,  32'd3,        32'hFFFFFFFE);
    issue(OP_MFHI, 32'h0,        32'h0);
    issue(4'b1110, 32'h12345678, 32'h9ABCDEF0);
    issue(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drain();
    chk("lit_nor_tail", bus.result, 32'h0);

    // Multi-cycle ops
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    drain();
    chk("lit_mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("lit_mult_lo", bus.lo, 32'hFFFFFFEB);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2);
    issue(OP_DIVU,  32'd7,        32'd0);
    drain();
    chk("lit_divu0_lo", bus.lo, 32'hFFFFFFFF);
    chk("lit_divu0_hi", bus.hi, 32'd7);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF);
    issue(OP_DIV,   32'hFFFFFFF9, 32'd0);
    issue(OP_DIV,   32'd7,        32'hFFFFFFFE);
    issue(OP_DIVU,  32'hFFFFFFFF, 32'd3);
    issue(OP_MULT,  32'h80000000, 32'h80000000);
    issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);

    // mflo held while a divide is in flight
    issue(OP_DIV,  32'd100, 32'd7);
    issue(OP_MFLO, 32'h0,   32'h0);
    issue(OP_MFHI, 32'h0,   32'h0);
    drain();
    chk("lit_mfhi_after_div", bus.result, 32'd2);
    chk("lit_lo_after_div", bus.lo, 32'd14);

    // Reset 10 cycles into a multiply
    issue(OP_MULT, 32'h12345678, 32'h0000ABCD);
    repeat (9) @(posedge clk);
    #1;
    do_reset();
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    chk("abort_in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("abort_out_valid", {31'b0, bus.out_valid}, 32'h0);
    issue(OP_ADD, 32'd2, 32'd3);
    drain();
    chk("lit_add_after_abort", bus.result, 32'd5);
    repeat (40) @(posedge clk);
    #1;

    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised successor to the datapath ALU for the MIPS core. It keeps the eight single-cycle integer operations and adds a multi-cycle iterative multiply/divide unit with architectural HI/LO registers. It exposes a valid/ready issue handshake so the execute stage can stall while a MULT/DIV is in flight. It sits in the EX stage and replaces the combinational ALU; all results are registered.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and even.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- a, b  in  WIDTH  operands (rs, rt).
- control  in  4  operation code (see Operation).
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready.
- out_valid  out  1  one-cycle pulse: result/of valid.
- result  out  WIDTH  registered result.
- of  out  1  signed overflow (add/sub only), qualified by out_valid.
- hi, lo  out  WIDTH  current HI/LO contents.

## Operation
- Single-cycle ops (control[3]=0): 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt signed, 0011 sltu, 0100 xor, 0101 nor.
  - Add/sub: sum = a + (control[2] ? ~b : b) + control[2], mod 2^WIDTH.
  - slt/sltu: result = zero-extended 1-bit compare.
  - of = (a[W-1] == b2[W-1]) & (sum[W-1] != a[W-1]) for add/sub; 0 for all other ops.
- Multi-cycle ops: 1000 mult, 1001 multu, 1010 div, 1011 divu.
  - mult/multu: {hi,lo} = full 2·WIDTH-bit product.
  - div/divu: lo = quotient, hi = remainder. Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: lo = all-ones, hi = a. Not an error.
  - Signed MIN / −1: lo = MIN, hi = 0.
- Move ops: 1100 mfhi → result = hi; 1101 mflo → result = lo.
- 1110, 1111 reserved: result = 0, of = 0.
- Iteration: radix-2, one bit per cycle, over magnitudes. Signed ops negate operands at load and fix signs on the final cycle.
- FSM states:
  - IDLE: in_ready=1.
    - Single-cycle or move op accepted → result registered, stay in IDLE.
    - Mult op → MUL. Div op → DIV.
  - MUL / DIV: in_ready=0. Iteration counter counts WIDTH cycles, then → FIN.
  - FIN: apply sign fix-up, write hi/lo, pulse out_valid with result = new lo, → IDLE.
- HI/LO change only in FIN and on reset.

## Timing
- Reset values: hi=0, lo=0, result=0, of=0, out_valid=0, state=IDLE. in_ready=1 the cycle after reset deasserts.
- Single-cycle/move op accepted in cycle N → out_valid=1 in N+1. Back-to-back issue gives one result per cycle.
- Mult/div accepted in cycle N:
  - in_ready=0 for cycles N+1 .. N+WIDTH+1.
  - out_valid and the hi/lo update occur in cycle N+WIDTH+1.
  - in_ready=1 again in N+WIDTH+2.
- mfhi issued in the cycle after FIN returns the new hi. There is no hazard window, because issue is blocked until then.
- Operands and control are sampled only on transfer; changes to them while busy are ignored.
- in_valid while in_ready=0 is not a transfer. The requester holds the op.
- No output back-pressure: the consumer must take out_valid when it occurs.
- Reset mid-operation aborts the iteration. hi/lo return to 0, no out_valid is produced, and the FSM goes to IDLE.

## Structure
- Shared package `alu_md_pkg`:
  - opcode localparams (OP_AND … OP_MFLO);
  - FSM state enum (IDLE, MUL, DIV, FIN).
- One sub-module, `alu_md_iter`: the shift-add/restoring-divide datapath with its counter, started and finished by the top FSM.
- The single-cycle logic stays in the top module.

## Test plan
- WIDTH=32, add 0x7FFFFFFF + 1 → result 0x80000000, of=1, out_valid one cycle later. sub 5−7 → 0xFFFFFFFE, of=0.
- slt −1,1 → 1; sltu 0xFFFFFFFF,1 → 0. nor 0,0 → 0xFFFFFFFF. Issued back-to-back: three out_valid pulses on consecutive cycles.
- mult −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, out_valid exactly 33 cycles after accept, in_ready low throughout. multu 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=1.
- div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 → lo=0xFFFFFFFF, hi=7. div 0x80000000/−1 → lo=0x80000000, hi=0.
- Issue mflo with in_valid held during a div → not accepted until in_ready rises, then returns the new quotient.
- Assert reset 10 cycles into a mult → no out_valid, hi=lo=0, in_ready=1 after reset; a following add completes normally.
